ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/ifetch_unit_npc.sv | 23 ++
 rtl/ifetch_unit.sv | 116 +++++++++++
 tb/tb_ifetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared next-PC op and fetch FSM encodings
package cpu_pkg;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JAL    = 2'd2,
        NPC_JALR   = 2'd3
    } npc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // A redirect only counts when it actually changes control flow.
    function automatic logic redirect_taken(logic valid, logic [1:0] op, logic taken);
        return valid && (op == NPC_JAL || op == NPC_JALR || (op == NPC_BRANCH && taken));
    endfunction

endpackage

// File: rtl/ifetch_unit_npc.sv
// npc: combinational redirect target for branch, JAL and JALR
module npc
    import cpu_pkg::*;
(
    input  logic [1:0]  npc_op,
    input  logic [31:0] br_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] target
);

    logic [31:0] w_pc_rel;
    logic [31:0] w_reg_rel;

    assign w_pc_rel  = br_pc + imm;
    assign w_reg_rel = rs1 + imm;

    // JALR clears bit 0; branch, JAL (and the unused PC4 case) are PC-relative.
    always_comb begin
        target = (npc_op == NPC_JALR) ? (w_reg_rel & ~32'd1) : w_pc_rel;
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-entry instruction fetch buffer with redirect handling
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    input  logic        redirect_valid,
    input  logic [1:0]  npc_op,
    input  logic [31:0] br_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        br_taken
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_inst;
    logic [31:0]  w_inst_nxt;
    logic [31:0]  r_id_pc;
    logic [31:0]  w_id_pc_nxt;
    logic         r_drop;
    logic         w_drop_nxt;
    logic [31:0]  w_target;
    logic [31:0]  w_target_aligned;
    logic         w_redirect;

    npc u_npc (
        .npc_op (npc_op),
        .br_pc  (br_pc),
        .imm    (imm),
        .rs1    (rs1),
        .target (w_target)
    );

    assign w_redirect       = redirect_taken(redirect_valid, npc_op, br_taken);
    assign w_target_aligned = w_target & ~32'd3;

    // Next-state logic: redirects win over both fetch responses and decode accepts.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_id_pc_nxt = r_id_pc;
        w_drop_nxt  = r_drop;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_redirect) begin
                    w_pc_nxt   = w_target_aligned;
                    // A response still in flight belongs to the old path.
                    w_drop_nxt = !imem_rvalid;
                end else if (imem_rvalid) begin
                    if (r_drop) begin
                        w_drop_nxt = 1'b0;
                    end else begin
                        w_inst_nxt  = imem_rdata;
                        w_id_pc_nxt = r_pc;
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target_aligned;
                    w_state_nxt = ST_FETCH;
                end else if (id_ready) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= 32'd0;
            r_id_pc <= 32'd0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_id_pc <= w_id_pc_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign imem_req  = (r_state == ST_FETCH) && !r_drop;
    assign imem_addr = r_pc;
    assign id_valid  = (r_state == ST_FULL);
    assign id_inst   = r_inst;
    assign id_pc     = r_id_pc;
    assign id_pc4    = r_id_pc + PC_STEP;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for the fetch unit
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        redirect_valid;
    logic [1:0]  npc_op;
    logic [31:0] br_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        br_taken;

    int checks = 0;
    int errors = 0;

    logic        m_busy;
    logic        m_rv;
    logic [31:0] m_addr;
    int          m_cnt;
    int          lat;
    logic        x_rv;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .redirect_valid (redirect_valid),
        .npc_op         (npc_op),
        .br_pc          (br_pc),
        .imm            (imm),
        .rs1            (rs1),
        .br_taken       (br_taken)
    );

    always #5 clk = ~clk;

    // Memory model: one response per accepted request after lat cycles; data tags the address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
            m_cnt  <= 0;
            m_addr <= 32'd0;
        end else if (m_rv) begin
            m_rv   <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt <= 1) m_rv <= 1'b1;
            m_cnt <= m_cnt - 1;
        end else if (imem_req) begin
            m_addr <= imem_addr;
            m_busy <= 1'b1;
            if (lat <= 1) m_rv <= 1'b1;
            else m_cnt <= lat - 1;
        end
    end

    assign imem_rvalid = m_rv | x_rv;
    assign imem_rdata  = {16'hC0DE, m_addr[15:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !id_valid; i++) tick();
        checks++;
        if (id_valid !== 1'b1) begin errors++; $display("FAIL %s timeout: id_valid=%b expected 1", name, id_valid); end
    endtask

    task automatic set_redirect(input logic v, input logic [1:0] op, input logic [31:0] bp, input logic [31:0] im, input logic [31:0] r, input logic tk);
        redirect_valid = v; npc_op = op; br_pc = bp; imm = im; rs1 = r; br_taken = tk;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_ready = 1'b0; x_rv = 1'b0; lat = 1;
        set_redirect(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        #12;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", id_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h exp 0", id_inst); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", id_pc); end
        tick();
        rst_n = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b exp 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: req=%b addr=%h exp 1/00000000", imem_req, imem_addr); end
        tick();
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'hC0DE0000) begin errors++; $display("FAIL first_inst: v=%b pc=%h inst=%h exp 1/0/C0DE0000", id_valid, id_pc, id_inst); end
        checks++; if (id_pc4 !== 32'h4 || imem_req !== 1'b0) begin errors++; $display("FAIL first_pc4: pc4=%h req=%b exp 4/0", id_pc4, imem_req); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL second_req: v=%b req=%b addr=%h exp 0/1/4", id_valid, imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        wait_valid("stall_wait");
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== 32'hC0DE0004 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: v=%b pc=%h inst=%h req=%b exp 1/4/C0DE0004/0", i, id_valid, id_pc, id_inst, imem_req);
            end
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next: req=%b addr=%h exp 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_jal();
        wait_valid("jal_wait");
        checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL jal_pre: pc=%h exp 8", id_pc); end
        set_redirect(1'b1, 2'd2, 32'h100, 32'hFFFF_FFF8, 32'd0, 1'b0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        set_redirect(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hF8) begin errors++; $display("FAIL jal_req: v=%b req=%b addr=%h exp 0/1/F8", id_valid, imem_req, imem_addr); end
        wait_valid("jal_fetch");
        checks++; if (id_pc !== 32'hF8 || id_inst !== 32'hC0DE00F8) begin errors++; $display("FAIL jal_inst: pc=%h inst=%h exp F8/C0DE00F8", id_pc, id_inst); end
    endtask

    task automatic test_jalr_drop();
        logic saw_rv = 1'b0;
        logic early = 1'b0;
        lat = 3;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFC) begin errors++; $display("FAIL jalr_pre: req=%b addr=%h exp 1/FC", imem_req, imem_addr); end
        tick();
        set_redirect(1'b1, 2'd3, 32'h0, 32'h4, 32'h203, 1'b0);
        tick();
        set_redirect(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h204) begin errors++; $display("FAIL jalr_drop: req=%b addr=%h exp 0/204", imem_req, imem_addr); end
        for (int i = 0; i < 8 && !imem_req; i++) begin
            if (imem_rvalid) saw_rv = 1'b1;
            if (id_valid) early = 1'b1;
            tick();
        end
        checks++; if (saw_rv !== 1'b1 || early !== 1'b0) begin errors++; $display("FAIL jalr_stale: saw_rv=%b early_valid=%b exp 1/0", saw_rv, early); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("FAIL jalr_req: req=%b addr=%h exp 1/204", imem_req, imem_addr); end
        wait_valid("jalr_fetch");
        checks++; if (id_pc !== 32'h204 || id_inst !== 32'hC0DE0204) begin errors++; $display("FAIL jalr_inst: pc=%h inst=%h exp 204/C0DE0204", id_pc, id_inst); end
    endtask

    task automatic test_branch_not_taken();
        logic [31:0] exp_pc [2];
        exp_pc[0] = 32'h208;
        exp_pc[1] = 32'h20C;
        lat = 1;
        set_redirect(1'b1, 2'd1, 32'h400, 32'h40, 32'd0, 1'b0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) npc_op = 2'd0;
            wait_valid("bnt_wait");
            checks++; if (id_pc !== exp_pc[i]) begin errors++; $display("FAIL bnt_seq[%0d]: pc=%h exp %h", i, id_pc, exp_pc[i]); end
            id_ready = 1'b1;
            tick();
            id_ready = 1'b0;
        end
        set_redirect(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h210) begin errors++; $display("FAIL bnt_next: req=%b addr=%h exp 1/210", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_with_rvalid();
        tick();
        set_redirect(1'b1, 2'd1, 32'h1000, 32'h10, 32'd0, 1'b1);
        tick();
        set_redirect(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1010) begin errors++; $display("FAIL same_cycle: v=%b req=%b addr=%h exp 0/1/1010", id_valid, imem_req, imem_addr); end
        wait_valid("same_cycle_wait");
        checks++; if (id_pc !== 32'h1010 || id_inst !== 32'hC0DE1010) begin errors++; $display("FAIL same_cycle_inst: pc=%h inst=%h exp 1010/C0DE1010", id_pc, id_inst); end
    endtask

    task automatic test_wrap();
        set_redirect(1'b1, 2'd2, 32'hFFFF_FFF0, 32'hF, 32'd0, 1'b0);
        tick();
        set_redirect(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: addr=%h exp FFFFFFFC", imem_addr); end
        wait_valid("wrap_wait");
        checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || id_inst !== 32'hC0DEFFFC) begin errors++; $display("FAIL wrap_inst: pc=%h pc4=%h inst=%h exp FFFFFFFC/0/C0DEFFFC", id_pc, id_pc4, id_inst); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        wait_valid("mid_pre");
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        lat = 3;
        tick();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL mid_pre_req: req=%b addr=%h exp 1/4", imem_req, imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: req=%b addr=%h v=%b exp 0/0/0", imem_req, imem_addr, id_valid); end
        checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0 || id_pc4 !== 32'h4) begin errors++; $display("FAIL mid_rst_data: inst=%h pc=%h pc4=%h exp 0/0/4", id_inst, id_pc, id_pc4); end
        lat = 1;
        tick();
        rst_n = 1'b1;
        x_rv = 1'b1;
        tick();
        x_rv = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart: v=%b req=%b addr=%h exp 0/1/0", id_valid, imem_req, imem_addr); end
        wait_valid("mid_wait");
        checks++; if (id_pc !== 32'h0 || id_inst !== 32'hC0DE0000) begin errors++; $display("FAIL mid_inst: pc=%h inst=%h exp 0/C0DE0000", id_pc, id_inst); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_jal();
        test_jalr_drop();
        test_branch_not_taken();
        test_redirect_with_rvalid();
        test_wrap();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
